// File: rtl/cg_rvarch_instr_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cg_rvarch_instr_enc_pkg
//  Purpose  : Shared types, opcode constants and the combinational
//             encode/check functions for the RV32I instruction encoder.
//             The functions are pure and can be reused by other blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package cg_rvarch_instr_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_RANGE    = 2'd1,
        ERR_MISALIGN = 2'd2,
        ERR_ILLEGAL  = 2'd3
    } err_code_e;

    localparam logic [6:0] C_OPC_OP     = 7'h33;
    localparam logic [6:0] C_OPC_OP_IMM = 7'h13;
    localparam logic [6:0] C_OPC_LOAD   = 7'h03;
    localparam logic [6:0] C_OPC_STORE  = 7'h23;
    localparam logic [6:0] C_OPC_BRANCH = 7'h63;
    localparam logic [6:0] C_OPC_LUI    = 7'h37;
    localparam logic [6:0] C_OPC_AUIPC  = 7'h17;
    localparam logic [6:0] C_OPC_JAL    = 7'h6F;
    localparam logic [6:0] C_OPC_JALR   = 7'h67;

    // Highest-priority failing check wins. Range checks verify the immediate
    // is the sign extension of the bits the format can actually carry.
    function automatic err_code_e enc_check(
        input logic [2:0]  fmt,
        input logic [6:0]  opcode,
        input logic [31:0] imm
    );
        err_code_e code;
        code = ERR_NONE;
        if ((fmt > 3'd5) || (opcode[1:0] != 2'b11)) begin
            code = ERR_ILLEGAL;
        end else if (((fmt == FMT_B) || (fmt == FMT_J)) && imm[0]) begin
            code = ERR_MISALIGN;
        end else begin
            case (fmt)
                FMT_I, FMT_S: if (!((&imm[31:11]) || (~|imm[31:11]))) code = ERR_RANGE;
                FMT_B:        if (!((&imm[31:12]) || (~|imm[31:12]))) code = ERR_RANGE;
                FMT_J:        if (!((&imm[31:20]) || (~|imm[31:20]))) code = ERR_RANGE;
                FMT_U:        if (imm[11:0] != 12'h000)               code = ERR_RANGE;
                default:      code = ERR_NONE;
            endcase
        end
        return code;
    endfunction

    function automatic logic [31:0] enc_instr(
        input logic [2:0]  fmt,
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (fmt)
            FMT_R:   w = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   w = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:   w = {imm[31:12], rd, opcode};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cg_rvarch_instr_fifo2.sv
`default_nettype none
// ============================================================================
//  Module   : cg_rvarch_instr_fifo2
//  Purpose  : 2-entry FIFO. The head entry is held in its own register so the
//             output is a flop and stays stable while not popped.
//  Ports    : i_clk, i_rst_n (async, active-low), i_push/i_data (write),
//             o_ready (count < 2), o_valid/o_data (head), i_pop (read)
//  Revision : 1.0 - initial release
// ============================================================================
module cg_rvarch_instr_fifo2 #(
    parameter int DATA_WIDTH = 35
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_pop
);

    logic [1:0]            r_count_q, w_count_d;
    logic [DATA_WIDTH-1:0] r_head_q,  w_head_d;
    logic [DATA_WIDTH-1:0] r_tail_q,  w_tail_d;
    logic                  w_push;
    logic                  w_pop;

    assign o_ready = (r_count_q != 2'd2);
    assign o_valid = (r_count_q != 2'd0);
    assign o_data  = r_head_q;

    assign w_push = i_push & o_ready;
    assign w_pop  = i_pop & o_valid;

    always_comb begin
        w_count_d = r_count_q;
        w_head_d  = r_head_q;
        w_tail_d  = r_tail_q;
        case ({w_push, w_pop})
            2'b10: begin
                if (r_count_q == 2'd0) w_head_d = i_data;
                else                   w_tail_d = i_data;
                w_count_d = r_count_q + 2'd1;
            end
            2'b01: begin
                w_head_d  = r_tail_q;
                w_count_d = r_count_q - 2'd1;
            end
            // Push and pop together only happen at count 1: the new entry
            // replaces the departing head directly.
            2'b11: w_head_d = i_data;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count_q <= 2'd0;
            r_head_q  <= '0;
            r_tail_q  <= '0;
        end else begin
            r_count_q <= w_count_d;
            r_head_q  <= w_head_d;
            r_tail_q  <= w_tail_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cg_rvarch_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : cg_rvarch_instr_encoder
//  Purpose  : Streaming RV32I encoder. Packs decoded fields into a 32-bit
//             instruction word, range-checks the request, buffers results in
//             a 2-entry FIFO and counts delivered good/errored responses.
//  Ports    : i_clk, i_rst_n (async, active-low)
//             request : i_req_valid/o_req_ready, i_fmt, i_opcode, i_rd, i_rs1,
//                       i_rs2, i_funct3, i_funct7, i_imm
//             response: o_rsp_valid/i_rsp_ready, o_instr, o_err, o_err_code
//             stats   : i_cnt_clr, o_cnt_ok, o_cnt_err
//  Revision : 1.0 - initial release
// ============================================================================
module cg_rvarch_instr_encoder
    import cg_rvarch_instr_enc_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [2:0]             i_fmt,
    input  logic [6:0]             i_opcode,
    input  logic [4:0]             i_rd,
    input  logic [4:0]             i_rs1,
    input  logic [4:0]             i_rs2,
    input  logic [2:0]             i_funct3,
    input  logic [6:0]             i_funct7,
    input  logic [31:0]            i_imm,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic                   o_err,
    output logic [1:0]             o_err_code,
    input  logic                   i_cnt_clr,
    output logic [CNT_WIDTH-1:0]   o_cnt_ok,
    output logic [CNT_WIDTH-1:0]   o_cnt_err
);

    localparam int C_DW = INSTR_WIDTH + 3;

    err_code_e             w_code;
    logic                  w_err;
    logic [INSTR_WIDTH-1:0] w_instr;
    logic                  w_fifo_ready;
    logic                  w_push;
    logic                  w_rsp_hs;
    logic [C_DW-1:0]       w_fifo_out;

    assign w_code  = enc_check(i_fmt, i_opcode, i_imm);
    assign w_err   = (w_code != ERR_NONE);
    assign w_instr = w_err ? '0
                           : enc_instr(i_fmt, i_opcode, i_rd, i_rs1, i_rs2,
                                       i_funct3, i_funct7, i_imm);

    // Gating with i_rst_n keeps ready low for the whole reset assertion,
    // not only after the async clear has propagated.
    assign o_req_ready = w_fifo_ready & i_rst_n;
    assign w_push      = i_req_valid & o_req_ready;
    assign w_rsp_hs    = o_rsp_valid & i_rsp_ready;

    cg_rvarch_instr_fifo2 #(
        .DATA_WIDTH (C_DW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  ({w_instr, w_err, w_code}),
        .o_ready (w_fifo_ready),
        .o_valid (o_rsp_valid),
        .o_data  (w_fifo_out),
        .i_pop   (i_rsp_ready)
    );

    assign o_instr    = w_fifo_out[C_DW-1:3];
    assign o_err      = w_fifo_out[2];
    assign o_err_code = w_fifo_out[1:0];

    logic [CNT_WIDTH-1:0] r_cnt_ok_q,  w_cnt_ok_d;
    logic [CNT_WIDTH-1:0] r_cnt_err_q, w_cnt_err_d;
    localparam logic [CNT_WIDTH-1:0] C_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        w_cnt_ok_d  = r_cnt_ok_q;
        w_cnt_err_d = r_cnt_err_q;
        if (i_cnt_clr) begin
            w_cnt_ok_d  = '0;
            w_cnt_err_d = '0;
        end else if (w_rsp_hs) begin
            if (o_err) begin
                if (r_cnt_err_q != '1) w_cnt_err_d = r_cnt_err_q + C_ONE;
            end else begin
                if (r_cnt_ok_q != '1)  w_cnt_ok_d  = r_cnt_ok_q + C_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt_ok_q  <= '0;
            r_cnt_err_q <= '0;
        end else begin
            r_cnt_ok_q  <= w_cnt_ok_d;
            r_cnt_err_q <= w_cnt_err_d;
        end
    end

    assign o_cnt_ok  = r_cnt_ok_q;
    assign o_cnt_err = r_cnt_err_q;

endmodule
`default_nettype wire

// File: doc/cg_rvarch_instr_encoder.md
# cg_rvarch_instr_encoder

Streaming RV32I instruction encoder: accepts decoded instruction fields (format, opcode, registers, functs, 32-bit immediate) over a valid/ready request port and emits the packed 32-bit instruction word over a valid/ready response port. It is the inverse of the field/immediate extraction logic and sits in instruction generators, self-test stimulus paths and assembler-in-hardware flows. Every request is range-checked and flagged. A 2-entry output buffer decouples request and response.

## Interface
- INSTR_WIDTH, 32, instruction word width (fixed at 32)
- CNT_WIDTH, 16, width of saturating statistics counters

- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request ready
- i_fmt  in  3  format: 0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
- i_opcode  in  7  opcode field
- i_rd / i_rs1 / i_rs2  in  5 each  register indices
- i_funct3  in  3;  i_funct7  in  7
- i_imm  in  32  immediate, sign-extended byte offset/value
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response ready
- o_instr  out  INSTR_WIDTH  encoded instruction
- o_err  out  1  request was rejected
- o_err_code  out  2  0 none, 1 imm range, 2 misaligned, 3 illegal fmt/opcode
- i_cnt_clr  in  1  synchronous clear of counters
- o_cnt_ok / o_cnt_err  out  CNT_WIDTH  delivered good / errored responses

## Operation
- Request accepted when i_req_valid && o_req_ready. Encode and check are combinational; the result is pushed into the 2-entry FIFO the same edge.
- Encoding (bit ranges of i_imm):
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
- Unused fields for a format are ignored (R ignores i_imm, U/J ignore rs1/rs2/funct*).
- Checks, priority high to low:
  - code 3: i_fmt>5 or i_opcode[1:0]!=2'b11
  - code 2: B/J with imm[0]=1
  - code 1: I/S imm[31:11] not all equal; B imm[31:12] not all equal; J imm[31:20] not all equal; U imm[11:0]!=0
- On any error: o_instr=32'h0, o_err=1.
- Counters increment on response handshake (o_cnt_err if o_err, else o_cnt_ok). Saturate at all-ones. i_cnt_clr wins over a same-cycle increment.

## Timing
- Latency: accept at edge N -> o_rsp_valid high after edge N (cycle N+1) when FIFO was empty.
- o_req_ready = (FIFO count < 2) && i_rst_n. No combinational path from i_rsp_ready. When full with a pop in the same cycle, the request is still not accepted.
- Simultaneous push and pop at count 1: count stays 1 and order is preserved.
- o_rsp_valid/o_instr/o_err/o_err_code are stable while o_rsp_valid && !i_rsp_ready.
- Reset (asynchronous, including mid-stream): FIFO emptied, o_rsp_valid=0, o_instr=0, o_err=0, o_err_code=0, counters=0, o_req_ready=0 while asserted. In-flight entries are discarded.

## Structure
- Shared package cg_rvarch_instr_enc_pkg holds:
  - fmt enum (R/I/S/B/U/J)
  - err_code enum
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR)
  - combinational encode/check functions, reusable by benches
- One sub-module: cg_rvarch_instr_fifo2, a 2-entry FIFO carrying {instr, err, err_code}, with count-based ready.

## Test plan
- R add x3,x1,x2 (fmt0, op 0x33, f3 0, f7 0) -> o_instr 0x002081B3, o_err 0, o_cnt_ok 1, one cycle after accept.
- I addi x1,x0,-1 (op 0x13, imm 0xFFFFFFFF) -> 0xFFF00093. U lui x5 (op 0x37, imm 0x12345000) -> 0x123452B7.
- B beq x1,x2,-4 (op 0x63, imm 0xFFFFFFFC) -> 0xFE208EE3. J imm 0x3 -> o_instr 0, code 2. I imm 0x800 -> code 1. fmt 6 -> code 3. o_cnt_err 3.
- Backpressure: i_rsp_ready=0, drive 3 requests -> 2 accepted, o_req_ready low. Then release -> outputs in order, third request accepted only after first pop.
- Counters: force o_cnt_ok near saturation -> holds at 0xFFFF. Assert i_cnt_clr with a same-cycle handshake -> reads 0.
- Assert i_rst_n low with 2 entries buffered -> all outputs 0 immediately. After release, a fresh request encodes correctly with no stale response.
